// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-collecting vending FSM that drives an external 3-bit adder and returns change one nickel per cycle.
// Define VEND_CANCEL_EN to make i_cancel refund the collected credit.
module vend_ctrl #(
    parameter logic [2:0] PRICE = 3'd4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_coin_valid,
    input  logic [1:0] i_coin,
    output logic       o_coin_ready,
    input  logic       i_cancel,
    output logic [2:0] o_add_a,
    output logic [2:0] o_add_b,
    output logic       o_add_cin,
    input  logic [2:0] i_add_sum,
    input  logic       i_add_cout,
    output logic [2:0] o_credit,
    output logic       o_dispense,
    output logic       o_change
);
`ifdef VEND_CANCEL_EN
    localparam logic CANCEL_EN = 1'b1;
`else
    localparam logic CANCEL_EN = 1'b0;
`endif
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] DISPENSE = 2'd2;
    localparam logic [1:0] CHANGE   = 2'd3;

    logic [1:0] state_q, state_d;
    logic [2:0] credit_q, credit_d;
    logic [3:0] chg_q, chg_d;
    logic       cancel_act, live, accept;
    logic [2:0] coin_val;
    logic [3:0] total;

    assign cancel_act   = CANCEL_EN & i_cancel;
    assign live         = (state_q == IDLE) || (state_q == COLLECT);
    // ready is gated by reset so no handshake can complete while held in reset
    assign o_coin_ready = i_rst_n & live & ~cancel_act;
    assign accept       = i_coin_valid & o_coin_ready;
    assign coin_val     = (i_coin == 2'b11) ? 3'd5 : {1'b0, i_coin};
    assign o_add_a      = credit_q;
    assign o_add_b      = accept ? coin_val : 3'd0;
    assign o_add_cin    = 1'b0;
    assign o_credit     = credit_q;
    assign o_dispense   = state_q == DISPENSE;
    assign o_change     = state_q == CHANGE;
    assign total        = {i_add_cout, i_add_sum};

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        chg_d    = chg_q;
        case (state_q)
            IDLE, COLLECT: begin
                if (cancel_act && state_q == COLLECT) begin
                    chg_d    = {1'b0, credit_q};
                    credit_d = 3'd0;
                    state_d  = (credit_q != 3'd0) ? CHANGE : IDLE;
                end else if (accept) begin
                    if (total >= {1'b0, PRICE}) begin
                        credit_d = 3'd0;
                        chg_d    = total - {1'b0, PRICE};
                        state_d  = DISPENSE;
                    end else begin
                        credit_d = total[2:0];
                        // a zero-value coin from IDLE completes the handshake without leaving IDLE
                        state_d  = (total != 4'd0) ? COLLECT : state_q;
                    end
                end
            end
            DISPENSE: state_d = (chg_q != 4'd0) ? CHANGE : IDLE;
            default: begin
                chg_d   = chg_q - 4'd1;
                state_d = (chg_q <= 4'd1) ? IDLE : CHANGE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            credit_q <= 3'd0;
            chg_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            chg_q    <= chg_d;
        end
    end
endmodule

// File: doc/vend_ctrl.md
VEND_CTRL -- requirements
Module: vend_ctrl

Interface
REQ-001 SHALL have parameter: PRICE, 3'd4, item price in nickel units (legal 1..7).
REQ-002 SHALL have port: i_clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: i_coin_valid  input  1  coin present.
REQ-005 SHALL have port: i_coin  input  2  coin code: 00 none (value 0), 01 nickel (1), 10 dime (2), 11 quarter (5).
REQ-006 SHALL have port: o_coin_ready  output  1  coin accepted when i_coin_valid and o_coin_ready are both high on a rising edge.
REQ-007 SHALL have port: i_cancel  input  1  refund request.
REQ-008 SHALL have port: o_add_a  output  3  credit register, driven to downstream 3-bit adder i_sum.
REQ-009 SHALL have port: o_add_b  output  3  coin value during an accept cycle, else 0; drives adder i_coin.
REQ-010 SHALL have port: o_add_cin  output  1  constant 0.
REQ-011 SHALL have port: i_add_sum  input  3  adder sum result.
REQ-012 SHALL have port: i_add_cout  input  1  adder carry out.
REQ-013 SHALL have port: o_credit  output  3  current credit, equal to o_add_a.
REQ-014 SHALL have port: o_dispense  output  1  one-cycle vend pulse.
REQ-015 SHALL have port: o_change  output  1  one pulse per returned nickel.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, DISPENSE, CHANGE.
REQ-017 SHALL drive o_coin_ready high only in IDLE or COLLECT with i_cancel low (cancel masked when macro absent).
REQ-018 SHALL, on accept, form total T = {i_add_cout, i_add_sum} (4 bits, max 11); the adder path is combinational within the accept cycle.
REQ-019 SHALL, on accept with T < PRICE, load credit <= T[2:0] and go to COLLECT.
REQ-020 SHALL, on accept with T >= PRICE, clear credit, load 4-bit change counter <= T - PRICE, and go to DISPENSE.
REQ-021 SHALL assert o_dispense for exactly the one cycle spent in DISPENSE (accept at edge N -> o_dispense high cycle N+1).
REQ-022 SHALL go DISPENSE -> CHANGE if change counter > 0, else -> IDLE.
REQ-023 SHALL, in CHANGE, assert o_change each cycle and decrement the counter; leaving to IDLE after the cycle where the counter is 1 (first o_change at cycle N+2, consecutive pulses, no gaps).
REQ-024 SHALL accept code 00 as a zero-value coin: handshake completes, credit unchanged, state unchanged unless credit >= PRICE (impossible by construction).
REQ-025 SHALL leave an unaccepted coin pending with no side effects; the upstream holds it until ready.

Reset
REQ-026 SHALL, while i_rst_n low, asynchronously force state IDLE, credit 0, change counter 0, o_dispense 0, o_change 0, o_coin_ready 0, o_add_b 0.
REQ-027 SHALL abort any in-progress DISPENSE/CHANGE on reset; remaining change is discarded.
REQ-028 SHALL raise o_coin_ready in the first cycle after i_rst_n deasserts.

Configuration
REQ-029 SHALL, with macro VEND_CANCEL_EN defined, on i_cancel high in COLLECT: load change counter <= credit, clear credit, go to CHANGE, no o_dispense; i_cancel in IDLE has no effect.
REQ-030 SHALL, with VEND_CANCEL_EN defined, ignore a simultaneous coin (ready low) when i_cancel is high.
REQ-031 SHALL, without VEND_CANCEL_EN, keep port i_cancel but ignore it entirely.

Verification (PRICE=4)
REQ-032 SHALL verify: dime, dime -> o_dispense one cycle after second accept, no o_change, credit 0, back to IDLE.
REQ-033 SHALL verify: quarter from IDLE -> o_dispense at N+1, exactly one o_change at N+2, ready high at N+3.
REQ-034 SHALL verify: three nickels then quarter (T=8) -> o_dispense, then four consecutive o_change pulses, o_coin_ready low throughout.
REQ-035 SHALL verify: coin held valid during CHANGE -> not accepted until IDLE, then credited exactly once.
REQ-036 SHALL verify: dime + nickel then i_cancel -> with VEND_CANCEL_EN three o_change pulses, no o_dispense; without it credit stays 3.
REQ-037 SHALL verify: i_rst_n low mid-CHANGE -> o_change and o_dispense 0 immediately, credit 0, no further pulses after release.
